// File: rtl/rv_pkg.sv
// Shared RISC-V constants used by the instruction fetch path.
package rv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned WORD_OFFSET = 2;
  localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage : rv_pkg

// File: rtl/imem_ram.sv
// Instruction storage: simple dual-port RAM, one synchronous write port and
// one synchronous read port. Read data holds while re is low.
module imem_ram
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WIDTH     = XLEN,
  parameter              INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : imem_ram

// File: rtl/imem_fetch_port.sv
// Instruction fetch port: valid/ready request and response channels over
// imem_ram, with error classification, flush and a consumed-response counter.
module imem_fetch_port
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = XLEN,
  parameter              INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic [31:0]              fetch_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

  logic             accept;
  logic             consume;
  logic             misaligned;
  logic             out_of_range;
  logic             fetch_err;
  logic [IDX_W-1:0] word_idx;
  logic [WIDTH-1:0] ram_rdata;
  logic             nop_sel_q;
  logic             nop_sel_d;
  logic             rsp_valid_d;
  logic             rsp_err_d;
  logic [31:0]      fetch_cnt_d;

  // Handshake and address classification; load and flush block new requests.
  always_comb begin
    req_ready    = !ld_en && !flush && (!rsp_valid || rsp_ready);
    accept       = req_valid && req_ready;
    consume      = rsp_valid && rsp_ready;
    misaligned   = req_addr[WORD_OFFSET-1:0] != '0;
    out_of_range = (req_addr >> (WORD_OFFSET + IDX_W)) != '0;
    fetch_err    = misaligned || out_of_range;
    word_idx     = req_addr[WORD_OFFSET +: IDX_W];
  end

  // Error responses and the reset state present NOP instead of RAM data.
  always_comb begin
    rsp_data = nop_sel_q ? NOP_W : ram_rdata;
  end

  // RAM is read only on a good accept so held data cannot change underneath.
  imem_ram #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (accept && !fetch_err),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // Next response state: flush wins, then accept, then consume clears.
  always_comb begin
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    nop_sel_d   = nop_sel_q;
    fetch_cnt_d = fetch_cnt;
    if (consume && (fetch_cnt != '1)) begin
      fetch_cnt_d = fetch_cnt + 32'd1;
    end
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fetch_err;
      nop_sel_d   = fetch_err;
    end else if (consume) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      nop_sel_q <= 1'b1;
      fetch_cnt <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      nop_sel_q <= nop_sel_d;
      fetch_cnt <= fetch_cnt_d;
    end
  end

endmodule : imem_fetch_port

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT.
module tb_imem_fetch_port;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;
  logic              flush;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic [31:0]       fetch_cnt;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_valid, m_ready, m_consume;

  imem_fetch_port #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: word-aligned in-range addresses read the model memory,
  // anything else is an error response carrying NOP.
  function automatic rsp_t expect_for(logic [31:0] a);
    rsp_t r;
    if ((a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH))) begin
      r.err  = 1'b1;
      r.data = NOP;
    end else begin
      r.err  = 1'b0;
      r.data = mdl_mem[a / 4];
    end
    return r;
  endfunction

  // Monitor: compare pre-edge DUT state with the model, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mdl_cnt = '0;
    end else begin
      m_valid   = sb.size() != 0;
      m_ready   = !ld_en && !flush && (!m_valid || rsp_ready);
      m_consume = m_valid && rsp_ready;
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("fetch_cnt", fetch_cnt, mdl_cnt);
      if (m_valid) begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
      end
      if (m_consume && (mdl_cnt != 32'hFFFF_FFFF)) mdl_cnt = mdl_cnt + 1;
      if (m_valid && (m_consume || flush)) void'(sb.pop_front());
      if (m_ready && req_valid) sb.push_back(expect_for(req_addr));
      if (ld_en) mdl_mem[ld_addr] = ld_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
  endtask

  task automatic req(logic [31:0] a, logic rr);
    cyc();
    idle();
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = rr;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom % 8)
      0, 1, 2, 3, 4: a = {22'd0, 8'($urandom % DEPTH), 2'b00};
      5:             a = {22'd0, 8'($urandom % DEPTH), 2'($urandom_range(1, 3))};
      6:             a = 32'h400 + ($urandom % 32'h1000);
      default:       a = $urandom;
    endcase
    return a;
  endfunction

  task automatic rand_cycles(int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      req_valid = ($urandom % 4) != 0;
      req_addr  = rand_addr();
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      ld_en     = ($urandom % 16) == 0;
      ld_addr   = 8'($urandom % DEPTH);
      ld_data   = $urandom;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", rsp_data, NOP);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    idle();
    rsp_ready = 1'b0;
    req_addr  = '0;
    ld_addr   = '0;
    ld_data   = '0;
    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
    mdl_cnt = '0;
    #1;
    check_reset_outputs();
    cyc();
    cyc();
    rst = 1'b0;

    // Program load mem[i] = i through the load port.
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc();
      ld_en     = 1'b1;
      ld_addr   = 8'(i);
      ld_data   = 32'(i);
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      rsp_ready = 1'($urandom);
    end

    // Back-to-back stream of three fetches.
    req(32'h0, 1'b1);
    req(32'h4, 1'b1);
    req(32'h8, 1'b1);
    cyc();
    idle();
    cyc();
    chk("stream_fetch_cnt", fetch_cnt, 32'd3);

    // Misaligned, out of range, and the last valid word.
    req(32'h6, 1'b1);
    req(32'h400, 1'b1);
    req(32'h3FC, 1'b1);
    req(32'h401, 1'b1);

    // Hold a response for three cycles with a competing request.
    req(32'h10, 1'b0);
    for (int i = 0; i < 3; i++) req(32'h20, 1'b0);
    req(32'h20, 1'b1);
    cyc();
    idle();

    // Load then fetch the same word.
    cyc();
    idle();
    ld_en     = 1'b1;
    ld_addr   = 8'd5;
    ld_data   = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_addr  = 32'h14;
    req(32'h14, 1'b1);
    cyc();
    idle();

    // Load while a response is held must not disturb it.
    req(32'h18, 1'b0);
    cyc();
    idle();
    ld_en   = 1'b1;
    ld_addr = 8'd6;
    ld_data = 32'hCAFE_F00D;
    cyc();
    idle();
    rsp_ready = 1'b1;

    // Flush of a pending response, and flush together with a consume.
    req(32'h1C, 1'b0);
    cyc();
    idle();
    flush = 1'b1;
    cyc();
    idle();
    req(32'h24, 1'b0);
    cyc();
    idle();
    flush     = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    idle();

    rand_cycles(1500);

    // Reset with a response in flight: outputs clear without a clock edge.
    req(32'h8, 1'b0);
    cyc();
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    cyc();
    rst = 1'b0;
    req(32'hC, 1'b1);
    rand_cycles(400);

    cyc();
    idle();
    rsp_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_fetch_port
